// File: rtl/ped_req_pkg.sv
// Shared definitions for the pedestrian request conditioner.
// Holds the request FSM state encoding and the default timing constants,
// which the RGY controller bench also uses.
package ped_req_pkg;

  // Request FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t PENDING = 2'd1;
  localparam state_t HOLDOFF = 2'd2;

  // Default timing / sizing constants shared with the controller bench
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_HOLDOFF_CYCLES  = 64;
  localparam int DEFAULT_CNT_W           = 8;

  // Bits needed to hold values 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ped_request_cond_if.sv
// Button / controller side signals of the pedestrian request conditioner.
// slave  : the conditioner itself (takes button and acknowledge, drives status)
// master : the surrounding logic (RGY controller and button pad)
interface ped_request_cond_if #(
  parameter int CNT_W = 8
) ();

  logic             btn_raw;
  logic             req_ack;
  logic             ped_req;
  logic             btn_clean;
  logic             holdoff;
  logic [CNT_W-1:0] req_count;

  modport master (
    output btn_raw,
    output req_ack,
    input  ped_req,
    input  btn_clean,
    input  holdoff,
    input  req_count
  );

  modport slave (
    input  btn_raw,
    input  req_ack,
    output ped_req,
    output btn_clean,
    output holdoff,
    output req_count
  );

endinterface

// File: rtl/ped_debounce.sv
// Two-flop synchroniser followed by a stability counter.
// btn_clean only follows the synchronised button after DEBOUNCE_CYCLES
// consecutive samples that disagree with the current clean level.
module ped_debounce
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  // Counter value at which the next disagreeing sample reaches DEBOUNCE_CYCLES
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [DW-1:0] db_cnt;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      btn_clean <= 1'b0;
    end else if (sync != btn_clean) begin
      if (db_cnt == LAST) begin
        btn_clean <= sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/ped_request_cond.sv
// Pedestrian push-button conditioner feeding the RGY controller.
// Debounced presses raise a level request (ped_req) that is held until the
// controller acknowledges it, followed by a hold-off window that discards
// further presses.
// Optional macro PED_REQ_COUNT_EN builds a saturating press counter on
// req_count; without it req_count is tied to zero.
module ped_request_cond
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEFAULT_HOLDOFF_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  ped_request_cond_if.slave  bus
);

  localparam int HW = cnt_width(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  logic          btn_clean;
  logic          btn_clean_prev;
  logic          press;

  state_t        state_reg;
  state_t        state_next;
  logic [HW-1:0] hold_cnt_reg;
  logic [HW-1:0] hold_cnt_next;
  logic          ped_req_reg;
  logic          ped_req_next;
  logic          holdoff_reg;
  logic          holdoff_next;

  ped_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (bus.btn_raw),
    .btn_clean (btn_clean)
  );

  // Only the rising edge of the clean level counts as a press
  assign press = btn_clean & ~btn_clean_prev;

  // State register, hold-off counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      ped_req_reg    <= 1'b0;
      holdoff_reg    <= 1'b0;
      btn_clean_prev <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      ped_req_reg    <= ped_req_next;
      holdoff_reg    <= holdoff_next;
      btn_clean_prev <= btn_clean;
    end
  end

  // Next-state logic: presses only count in IDLE, acknowledge only in PENDING
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (press) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        // Acknowledge takes priority; a coincident press is simply merged away
        if (bus.req_ack) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next    = HOLDOFF;
            hold_cnt_next = HOLD_LOAD;
          end
        end
      end
      HOLDOFF: begin
        // The cycle holding value 1 is the last hold-off cycle
        if (hold_cnt_reg <= HW'(1)) begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs leave a flop
  always_comb begin
    ped_req_next = (state_next == PENDING);
    holdoff_next = (state_next == HOLDOFF);
  end

  assign bus.ped_req   = ped_req_reg;
  assign bus.holdoff   = holdoff_reg;
  assign bus.btn_clean = btn_clean;

`ifdef PED_REQ_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  // Count accepted presses (IDLE to PENDING), sticking at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if ((state_reg == IDLE) && (state_next == PENDING) && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.req_count = count_reg;
`else
  assign bus.req_count = '0;
`endif

endmodule

// File: tb/tb_ped_request_cond.sv
// Self-checking bench for ped_request_cond.
// Stimulus is a table of segments {reset, btn_raw, req_ack, length, expected
// outputs}; each driven cycle pushes its expectation into a scoreboard queue
// that is popped and compared just after the clock edge.
module tb_ped_request_cond;

  localparam int DB = 4;
  localparam int HO = 8;
  localparam int CW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ped_request_cond_if #(.CNT_W(CW)) bus ();

  ped_request_cond #(
    .DEBOUNCE_CYCLES (DB),
    .HOLDOFF_CYCLES  (HO),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic raw;
    logic ack;
    int   n;
    logic c;
    logic r;
    logic h;
    int   cnt;
  } seg_t;

  typedef struct {
    logic          c;
    logic          r;
    logic          h;
    logic [CW-1:0] cnt;
    int            idx;
  } exp_t;

  seg_t segs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seg_base = 0;

  // Expected press count: real count with the counter built, else zero
  function automatic int ec(input int n);
`ifdef PED_REQ_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic add(input logic rst, input logic raw, input logic ack, input int n,
                     input logic c, input logic r, input logic h, input int cnt);
    seg_t s;
    s.rst = rst; s.raw = raw; s.ack = ack; s.n = n;
    s.c = c; s.r = r; s.h = h; s.cnt = cnt;
    segs.push_back(s);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s seg %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Full accepted press, acknowledge and hold-off, button released during hold-off
  task automatic add_press(input int prev, input int nxt);
    add(1, 1, 0, 5, 0, 0, 0, prev);
    add(1, 1, 0, 1, 1, 0, 0, prev);
    add(1, 1, 0, 1, 1, 1, 0, nxt);
    add(1, 1, 1, 1, 1, 0, 1, nxt);
    add(1, 0, 0, 5, 1, 0, 1, nxt);
    add(1, 0, 0, 2, 0, 0, 1, nxt);
    add(1, 0, 0, 2, 0, 0, 0, nxt);
  endtask

  task automatic run_segs();
    exp_t e;
    exp_t got;
    for (int i = 0; i < segs.size(); i++) begin
      for (int k = 0; k < segs[i].n; k++) begin
        @(negedge clk);
        reset       = segs[i].rst;
        bus.btn_raw = segs[i].raw;
        bus.req_ack = segs[i].ack;
        e.c   = segs[i].c;
        e.r   = segs[i].r;
        e.h   = segs[i].h;
        e.cnt = CW'(segs[i].cnt);
        e.idx = seg_base + i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        $display("seg %0d cyc %0d: raw=%0b ack=%0b clean=%0b req=%0b hold=%0b cnt=%0d",
                 got.idx, k, segs[i].raw, segs[i].ack, bus.btn_clean, bus.ped_req,
                 bus.holdoff, bus.req_count);
        chk("btn_clean", got.idx, 8'(bus.btn_clean), 8'(got.c));
        chk("ped_req",   got.idx, 8'(bus.ped_req),   8'(got.r));
        chk("holdoff",   got.idx, 8'(bus.holdoff),   8'(got.h));
        chk("req_count", got.idx, 8'(bus.req_count), 8'(got.cnt));
      end
    end
    seg_base += segs.size();
    segs.delete();
  endtask

  initial begin
    bus.btn_raw = 1'b1;
    bus.req_ack = 1'b0;
    reset       = 1'b0;

    // Reset held with button pressed, then release: clean press
    add(0, 1, 0, 3, 0, 0, 0, 0);
    add(1, 1, 0, 5, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 6, 1, 1, 0, ec(1));
    // Release: falling clean edge leaves the request pending
    add(1, 0, 0, 5, 1, 1, 0, ec(1));
    add(1, 0, 0, 3, 0, 1, 0, ec(1));
    // Acknowledge, then a clean press inside the hold-off window is ignored
    add(1, 0, 1, 1, 0, 0, 1, ec(1));
    add(1, 1, 0, 5, 0, 0, 1, ec(1));
    add(1, 1, 0, 2, 1, 0, 1, ec(1));
    add(1, 1, 0, 1, 1, 0, 0, ec(1));
    add(1, 1, 0, 3, 1, 0, 0, ec(1));
    add(1, 0, 0, 5, 1, 0, 0, ec(1));
    add(1, 0, 0, 2, 0, 0, 0, ec(1));
    // Acknowledge while idle is ignored
    add(1, 0, 1, 1, 0, 0, 0, ec(1));
    add(1, 0, 0, 1, 0, 0, 0, ec(1));
    // Bounce rejection
    for (int b = 0; b < 4; b++) begin
      add(1, 1, 0, 2, 0, 0, 0, ec(1));
      add(1, 0, 0, 2, 0, 0, 0, ec(1));
    end
    add(1, 0, 0, 4, 0, 0, 0, ec(1));
    // Second press goes pending; released and re-pressed so that the new
    // rising edge coincides with the acknowledge
    add(1, 1, 0, 5, 0, 0, 0, ec(1));
    add(1, 1, 0, 1, 1, 0, 0, ec(1));
    add(1, 1, 0, 1, 1, 1, 0, ec(2));
    add(1, 0, 0, 5, 1, 1, 0, ec(2));
    add(1, 0, 0, 1, 0, 1, 0, ec(2));
    add(1, 1, 0, 5, 0, 1, 0, ec(2));
    add(1, 1, 0, 1, 1, 1, 0, ec(2));
    add(1, 1, 1, 1, 1, 0, 1, ec(2));
    add(1, 1, 0, 7, 1, 0, 1, ec(2));
    add(1, 1, 0, 1, 1, 0, 0, ec(2));
    add(1, 1, 0, 3, 1, 0, 0, ec(2));
    add(1, 0, 0, 5, 1, 0, 0, ec(2));
    add(1, 0, 0, 1, 0, 0, 0, ec(2));
    // Presses three to five: counter saturates at 3
    add_press(ec(2), ec(3));
    add_press(ec(3), ec(3));
    add_press(ec(3), ec(3));
    // Go pending once more before the asynchronous reset
    add(1, 1, 0, 5, 0, 0, 0, ec(3));
    add(1, 1, 0, 1, 1, 0, 0, ec(3));
    add(1, 1, 0, 1, 1, 1, 0, ec(3));
    run_segs();

    // Asynchronous reset between clock edges clears outputs at once
    #2;
    reset       = 1'b0;
    bus.btn_raw = 1'b0;
    #1;
    $display("async reset: req=%0b hold=%0b clean=%0b cnt=%0d",
             bus.ped_req, bus.holdoff, bus.btn_clean, bus.req_count);
    chk("async_ped_req",   -1, 8'(bus.ped_req),   8'd0);
    chk("async_holdoff",   -1, 8'(bus.holdoff),   8'd0);
    chk("async_btn_clean", -1, 8'(bus.btn_clean), 8'd0);
    chk("async_req_count", -1, 8'(bus.req_count), 8'd0);

    // After release: idle, no replayed request, then a fresh press works
    add(1, 0, 0, 8, 0, 0, 0, 0);
    add_press(0, ec(1));
    run_segs();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_request_cond.md
# ped_request_cond

Pedestrian push-button conditioner that sits directly upstream of the RGY traffic-light controller. It synchronises and debounces the raw crossing button and turns each accepted press into a level request. That request is held toward the controller until acknowledged, then followed by a hold-off window in which further presses are ignored. Its output is the controller's only pedestrian input.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to change `btn_clean`; legal range ≥1.
- HOLDOFF_CYCLES, 64, cycles after acknowledge during which presses are discarded; 0 is legal.
- CNT_W, 8, width of `req_count`.

Ports:
- clk  in  1  system clock, same clock as the RGY controller.
- reset  in  1  asynchronous, active-low reset; the port is named `reset` as elsewhere in the codebase.
- btn_raw  in  1  raw button level, asynchronous to `clk`, may bounce.
- req_ack  in  1  one-cycle pulse from the controller when it commits to a pedestrian phase.
- ped_req  out  1  pedestrian request level toward the controller.
- btn_clean  out  1  debounced button level.
- holdoff  out  1  high while the hold-off window is active.
- req_count  out  CNT_W  saturating count of accepted presses.

## Operation
- **Reset values.** While `reset`=0, all flops clear: both sync stages, debounce counter, `btn_clean`, `ped_req`, `holdoff`, `req_count` all 0, FSM in IDLE.
- **Synchroniser.** Two flops, `btn_raw` → `sync`.
- **Debounce counter.**
  - When `sync` ≠ `btn_clean`, the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, `btn_clean` takes `sync` and the counter clears.
  - Any cycle with `sync` = `btn_clean` clears the counter.
- **Press.** A press is a one-cycle pulse on the rising edge of `btn_clean`. Falling edges are ignored.
- **FSM states:**
  - IDLE: `ped_req`=0, `holdoff`=0. A press moves to PENDING.
  - PENDING: `ped_req`=1. Further presses merge into the pending request and are not counted. `req_ack`=1 moves to HOLDOFF and loads the hold-off counter with HOLDOFF_CYCLES. If HOLDOFF_CYCLES=0, `req_ack` moves straight to IDLE instead.
  - HOLDOFF: `ped_req`=0, `holdoff`=1. The hold-off counter decrements each cycle; at value 1 the FSM returns to IDLE. Presses are discarded.
- **Acknowledge outside PENDING.** `req_ack` in IDLE or HOLDOFF is ignored.
- **Simultaneous press and `req_ack` in PENDING.** The acknowledge wins and the press is dropped.
- **Press on the exit edge of HOLDOFF.** Discarded. Only presses sampled while in IDLE are accepted.
- **Counter widths.** Debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits; hold-off counter is $clog2(HOLDOFF_CYCLES+1) bits, minimum 1. Neither wraps.

## Timing
- A clean `btn_raw` rise sampled at edge 0 gives `btn_clean`=1 after edge DEBOUNCE_CYCLES+2.
- `ped_req` rises one edge after `btn_clean`, i.e. after edge DEBOUNCE_CYCLES+3.
- `ped_req` falls and `holdoff` rises on the edge that samples `req_ack`=1.
- `holdoff` stays high for exactly HOLDOFF_CYCLES cycles.
- A second accepted press needs `btn_clean` to fall and rise again after IDLE is re-entered.
- Reset asserted mid-operation clears `ped_req` and `holdoff` immediately, without waiting for a clock edge. Any pending request is lost and not replayed.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- The macro `PED_REQ_COUNT_EN` controls the press counter.
- **Defined:** `req_count` increments by 1 on each IDLE→PENDING transition and saturates at 2^CNT_W−1. Only reset clears it.
- **Undefined:** no counter flops are built and `req_count` is tied to 0. The port stays present so the integration is identical either way.

## Structure
- Package `ped_req_pkg` holds:
  - the FSM state encoding as localparams: IDLE=2'd0, PENDING=2'd1, HOLDOFF=2'd2;
  - shared default constants for DEBOUNCE_CYCLES and HOLDOFF_CYCLES, which the RGY controller bench also uses.
- One sub-module, `ped_debounce`, contains the synchroniser and debounce counter. It takes `clk`, `reset`, `btn_raw` and outputs `btn_clean`.
- The request FSM, hold-off counter and press counter stay in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, CNT_W=2, `PED_REQ_COUNT_EN` defined unless noted.
- **Reset values.** Hold `reset`=0 for 3 cycles with `btn_raw`=1 → all outputs 0. Release → `btn_clean` rises 6 edges later.
- **Clean press.** `btn_raw` high from edge 0 for 12 cycles → `btn_clean`=1 after edge 6, `ped_req`=1 after edge 7, `req_count`=1.
- **Bounce rejection.** Toggle `btn_raw` every 2 cycles for 16 cycles, then hold 0 → `btn_clean`, `ped_req` and `req_count` all stay 0.
- **Handshake and hold-off.** One-cycle `req_ack` in PENDING → `ped_req`=0 and `holdoff`=1 for exactly 8 cycles. A clean press inside that window is ignored: no `ped_req`, `req_count` unchanged.
- **Simultaneous events and saturation.** Press edge coincident with `req_ack` in PENDING → HOLDOFF, no new request. Five accepted presses → `req_count`=3. With the macro undefined → `req_count` stays 0.
- **Reset mid-operation.** Drive `reset` low asynchronously while in PENDING → `ped_req` goes to 0 before the next clock edge. After release the FSM is in IDLE with no request.
